// File: rtl/encoder_tx_scheduler.sv
// Shares one combine_encoder between a UDP client (0) and a TCP client (1).
// Round-robin arbitration, encoder reset/start sequencing, payload streaming
// from the granted client's show-ahead FIFO, and done/err reporting per client.
//
// Ports:
//   clk_i            rising-edge clock
//   reset_i          synchronous active-high reset
//   req_i[1:0]       per-client level request, held until done_o[i]
//   len0_i, len1_i   payload byte count of client 0 / client 1
//   pl_data0_i/1_i   head word of each client FIFO (show-ahead)
//   pl_empty_i[1:0]  per-client FIFO empty
//   pl_rd_en_o[1:0]  per-client pop strobe (granted bit only)
//   gnt_o[1:0]       one-hot grant, RST_ENC through DONE/ABORT
//   done_o[1:0]      one-cycle completion pulse
//   err_o[1:0]       one-cycle error pulse, coincident with done_o
//   enc_reset_o      encoder reset pulse
//   enc_start_o      encoder start, high for the whole payload transfer
//   enc_data_av_o    enc_data_o valid
//   enc_data_o       payload word to the encoder
//   enc_udp0_tcp1_o  0 = UDP (client 0), 1 = TCP (client 1)
//   enc_len_o        latched length of the granted request
//   enc_fin_i        encoder packet-complete pulse
module encoder_tx_scheduler #(
    parameter int unsigned MAX_LEN        = 1460,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    input  logic [15:0] len0_i,
    input  logic [15:0] len1_i,
    input  logic [31:0] pl_data0_i,
    input  logic [31:0] pl_data1_i,
    input  logic [1:0]  pl_empty_i,
    output logic [1:0]  pl_rd_en_o,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    output logic        enc_reset_o,
    output logic        enc_start_o,
    output logic        enc_data_av_o,
    output logic [31:0] enc_data_o,
    output logic        enc_udp0_tcp1_o,
    output logic [15:0] enc_len_o,
    input  logic        enc_fin_i
);

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WORDS_W = 15;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_ENC,
        S_FEED,
        S_WAIT_FIN,
        S_DONE,
        S_ABORT
    } state_e;

    state_e               state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [WORDS_W-1:0]   words_q, words_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [1:0]           done_q, done_d;
    logic [1:0]           err_q, err_d;
    logic                 enc_reset_q, enc_reset_d;
    logic                 enc_start_q, enc_start_d;
    logic                 enc_data_av_q, enc_data_av_d;
    logic [DATA_W-1:0]    enc_data_q, enc_data_d;
    logic                 enc_udp0_tcp1_q, enc_udp0_tcp1_d;
    logic [LEN_W-1:0]     enc_len_q, enc_len_d;

    // Arbitration and request qualification for the IDLE decision
    logic                 winner_c;
    logic [LEN_W-1:0]     req_len_c;
    logic [WORDS_W-1:0]   req_words_c;
    logic                 len_ok_c;
    logic                 pop_c;
    logic [DATA_W-1:0]    head_data_c;

    assign winner_c    = (req_i == 2'b11) ? rr_ptr_q : req_i[1];
    assign req_len_c   = winner_c ? len1_i : len0_i;
    // 17-bit sum so 65535 bytes rounds up to 16384 words without wrapping
    assign req_words_c = WORDS_W'((17'(req_len_c) + 17'd3) >> 2);
    assign len_ok_c    = (req_len_c != '0) && (32'(req_len_c) <= MAX_LEN);
    assign head_data_c = gnt_q[1] ? pl_data1_i : pl_data0_i;

    // Pop is the registered grant qualified by the live empty flag, so the
    // show-ahead FIFO is never popped on a stale empty; reset blocks it at once.
    assign pop_c      = (state_q == S_FEED) && (words_q != '0) &&
                        ((gnt_q & ~pl_empty_i) != 2'b00);
    assign pl_rd_en_o = (pop_c && !reset_i) ? gnt_q : 2'b00;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= 1'b0;
            gnt_q           <= '0;
            words_q         <= '0;
            timer_q         <= '0;
            done_q          <= '0;
            err_q           <= '0;
            enc_reset_q     <= 1'b0;
            enc_start_q     <= 1'b0;
            enc_data_av_q   <= 1'b0;
            enc_data_q      <= '0;
            enc_udp0_tcp1_q <= 1'b0;
            enc_len_q       <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            gnt_q           <= gnt_d;
            words_q         <= words_d;
            timer_q         <= timer_d;
            done_q          <= done_d;
            err_q           <= err_d;
            enc_reset_q     <= enc_reset_d;
            enc_start_q     <= enc_start_d;
            enc_data_av_q   <= enc_data_av_d;
            enc_data_q      <= enc_data_d;
            enc_udp0_tcp1_q <= enc_udp0_tcp1_d;
            enc_len_q       <= enc_len_d;
        end
    end

    // Next state; registered outputs are computed so they line up with the state they belong to
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_d           = gnt_q;
        words_d         = words_q;
        timer_d         = timer_q;
        done_d          = 2'b00;
        err_d           = 2'b00;
        enc_reset_d     = 1'b0;
        enc_start_d     = 1'b0;
        enc_data_av_d   = 1'b0;
        enc_data_d      = enc_data_q;
        enc_udp0_tcp1_d = enc_udp0_tcp1_q;
        enc_len_d       = enc_len_q;

        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d           = winner_c ? 2'b10 : 2'b01;
                    rr_ptr_d        = ~winner_c;
                    enc_udp0_tcp1_d = winner_c;
                    enc_len_d       = req_len_c;
                    words_d         = req_words_c;
                    timer_d         = '0;
                    if (len_ok_c) begin
                        state_d     = S_RST_ENC;
                        enc_reset_d = 1'b1;
                    end else begin
                        // Rejected without touching the encoder
                        state_d = S_ABORT;
                        done_d  = gnt_d;
                        err_d   = gnt_d;
                    end
                end
            end

            S_RST_ENC: begin
                state_d     = S_FEED;
                enc_start_d = 1'b1;
                timer_d     = '0;
            end

            S_FEED: begin
                enc_start_d = 1'b1;
                if (pop_c) begin
                    enc_data_d    = head_data_c;
                    enc_data_av_d = 1'b1;
                    words_d       = words_q - WORDS_W'(1);
                    timer_d       = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end

                if (enc_fin_i) begin
                    // Encoder finished before it had the whole payload
                    state_d       = S_ABORT;
                    enc_start_d   = 1'b0;
                    enc_data_av_d = 1'b0;
                    enc_reset_d   = 1'b1;
                    done_d        = gnt_q;
                    err_d         = gnt_q;
                end else if (pop_c && (words_q == WORDS_W'(1))) begin
                    // Last word shows on enc_data in the first WAIT_FIN cycle
                    state_d = S_WAIT_FIN;
                    timer_d = '0;
                end else if (!pop_c && (timer_q == TIMER_LAST)) begin
                    state_d       = S_ABORT;
                    enc_start_d   = 1'b0;
                    enc_reset_d   = 1'b1;
                    done_d        = gnt_q;
                    err_d         = gnt_q;
                end
            end

            S_WAIT_FIN: begin
                if (enc_fin_i) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = S_ABORT;
                    enc_reset_d = 1'b1;
                    done_d      = gnt_q;
                    err_d       = gnt_q;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_DONE: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end

            S_ABORT: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    assign gnt_o           = gnt_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign enc_reset_o     = enc_reset_q;
    assign enc_start_o     = enc_start_q;
    assign enc_data_av_o   = enc_data_av_q;
    assign enc_data_o      = enc_data_q;
    assign enc_udp0_tcp1_o = enc_udp0_tcp1_q;
    assign enc_len_o       = enc_len_q;

endmodule

// File: tb/tb_encoder_tx_scheduler.sv
// Directed bench for encoder_tx_scheduler: two show-ahead FIFO models feed
// the DUT, a linear sequence of steps drives requests/fin and checks outputs.
module tb_encoder_tx_scheduler;

    localparam int unsigned MAX_LEN        = 1460;
    localparam int unsigned TIMEOUT_CYCLES = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] len0, len1;
    logic [31:0] pl_data0, pl_data1;
    logic [1:0]  pl_empty;
    logic [1:0]  pl_rd_en;
    logic [1:0]  gnt, done, err;
    logic        enc_reset, enc_start, enc_data_av, enc_udp0_tcp1, enc_fin;
    logic [31:0] enc_data;
    logic [15:0] enc_len;

    int errors = 0;
    int checks = 0;

    // Show-ahead FIFO models: words pushed by the stimulus, popped on pl_rd_en
    logic [31:0] mem0 [0:15];
    logic [31:0] mem1 [0:15];
    int wr0 = 0, wr1 = 0;
    int rp0 = 0, rp1 = 0;

    logic [31:0] rx [0:7];
    int n_rx;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_rd_en[0]) rp0 <= rp0 + 1;
        if (pl_rd_en[1]) rp1 <= rp1 + 1;
    end

    assign pl_empty = {(rp1 >= wr1), (rp0 >= wr0)};
    assign pl_data0 = mem0[rp0[3:0]];
    assign pl_data1 = mem1[rp1[3:0]];

    encoder_tx_scheduler #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .req_i           (req),
        .len0_i          (len0),
        .len1_i          (len1),
        .pl_data0_i      (pl_data0),
        .pl_data1_i      (pl_data1),
        .pl_empty_i      (pl_empty),
        .pl_rd_en_o      (pl_rd_en),
        .gnt_o           (gnt),
        .done_o          (done),
        .err_o           (err),
        .enc_reset_o     (enc_reset),
        .enc_start_o     (enc_start),
        .enc_data_av_o   (enc_data_av),
        .enc_data_o      (enc_data),
        .enc_udp0_tcp1_o (enc_udp0_tcp1),
        .enc_len_o       (enc_len),
        .enc_fin_i       (enc_fin)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push0(input logic [31:0] w);
        mem0[wr0[3:0]] = w;
        wr0++;
    endtask

    task automatic push1(input logic [31:0] w);
        mem1[wr1[3:0]] = w;
        wr1++;
    endtask

    // Called in the IDLE cycle where the request is visible; ends in the IDLE cycle after DONE
    task automatic xfer(input string tag, input logic [1:0] g, input int nw, input logic [1:0] req_after);
        step();
        chk($sformatf("%s.gnt", tag), 64'(gnt), 64'(g));
        chk($sformatf("%s.enc_reset", tag), 64'(enc_reset), 64'd1);
        chk($sformatf("%s.tcp", tag), 64'(enc_udp0_tcp1), 64'(g[1]));
        n_rx = 0;
        for (int c = 0; c < 64 && n_rx < nw; c++) begin
            step();
            chk($sformatf("%s.start", tag), 64'(enc_start), 64'd1);
            if (enc_data_av === 1'b1) begin
                rx[n_rx[2:0]] = enc_data;
                n_rx++;
            end
        end
        chk($sformatf("%s.words", tag), 64'(n_rx), 64'(nw));
        step();
        chk($sformatf("%s.start_off", tag), 64'({enc_start, enc_data_av}), 64'd0);
        enc_fin = 1'b1;
        step();
        enc_fin = 1'b0;
        chk($sformatf("%s.done", tag), 64'(done), 64'(g));
        chk($sformatf("%s.err", tag), 64'(err), 64'd0);
        req = req_after;
        step();
        chk($sformatf("%s.idle", tag), 64'({done, gnt}), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;
        reset   = 1'b1;
        req     = 2'b00;
        len0    = 16'd0;
        len1    = 16'd0;
        enc_fin = 1'b0;
        step();
        step();
        chk("rst.outs", 64'({gnt, done, err, pl_rd_en, enc_reset, enc_start, enc_data_av, enc_udp0_tcp1}), 64'd0);
        chk("rst.data", 64'({enc_data, enc_len}), 64'd0);
        reset = 1'b0;

        // 1: TCP client, 11 bytes -> 3 words "Hell" "o Wo" "rld\0"
        push1(32'h48656c6c);
        push1(32'h6f20576f);
        push1(32'h726c6400);
        len1 = 16'd11;
        req  = 2'b10;
        xfer("t1", 2'b10, 3, 2'b00);
        chk("t1.w0", 64'(rx[0]), 64'h48656c6c);
        chk("t1.w1", 64'(rx[1]), 64'h6f20576f);
        chk("t1.w2", 64'(rx[2]), 64'h726c6400);
        chk("t1.len", 64'(enc_len), 64'd11);
        chk("t1.popped", 64'(rp1), 64'd3);

        // 2: simultaneous requests alternate through rr_ptr
        reset = 1'b1;
        step();
        reset = 1'b0;
        push0(32'hA0A0A0A0); push0(32'hA1A1A1A1); push0(32'hA2A2A2A2); push0(32'hA3A3A3A3);
        push1(32'hB0B0B0B0); push1(32'hB1B1B1B1); push1(32'hB2B2B2B2); push1(32'hB3B3B3B3);
        len0 = 16'd8;
        len1 = 16'd8;
        req  = 2'b11;
        xfer("t2a", 2'b01, 2, 2'b11);
        chk("t2a.w0", 64'(rx[0]), 64'hA0A0A0A0);
        chk("t2a.w1", 64'(rx[1]), 64'hA1A1A1A1);
        xfer("t2b", 2'b10, 2, 2'b11);
        chk("t2b.w0", 64'(rx[0]), 64'hB0B0B0B0);
        chk("t2b.w1", 64'(rx[1]), 64'hB1B1B1B1);
        xfer("t2c", 2'b01, 2, 2'b10);
        chk("t2c.w0", 64'(rx[0]), 64'hA2A2A2A2);
        xfer("t2d", 2'b10, 2, 2'b00);
        chk("t2d.w1", 64'(rx[1]), 64'hB3B3B3B3);

        // 3: 12 bytes on client 0 with a 4-cycle empty FIFO after the first word
        push0(32'hC0C0C0C0);
        len0 = 16'd12;
        req  = 2'b01;
        step();
        chk("t3.enc_reset", 64'(enc_reset), 64'd1);
        step();
        chk("t3.pop0", 64'(pl_rd_en), 64'd1);
        chk("t3.start0", 64'(enc_start), 64'd1);
        step();
        chk("t3.av0", 64'({enc_data_av, enc_data}), {31'd0, 1'b1, 32'hC0C0C0C0});
        chk("t3.nopop", 64'(pl_rd_en), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3.stall%0d", k), 64'({enc_start, enc_data_av}), 64'b10);
        end
        push0(32'hC1C1C1C1);
        push0(32'hC2C2C2C2);
        #1;
        chk("t3.pop1", 64'(pl_rd_en), 64'd1);
        step();
        chk("t3.av1", 64'({enc_data_av, enc_data}), {31'd0, 1'b1, 32'hC1C1C1C1});
        step();
        chk("t3.av2", 64'({enc_data_av, enc_data}), {31'd0, 1'b1, 32'hC2C2C2C2});
        chk("t3.stop", 64'(pl_rd_en), 64'd0);
        step();
        chk("t3.start_off", 64'({enc_start, enc_data_av}), 64'd0);
        enc_fin = 1'b1;
        step();
        enc_fin = 1'b0;
        chk("t3.done", 64'({done, err}), 64'b0100);
        req = 2'b00;
        step();

        // 4: illegal lengths are rejected without touching the encoder
        push0(32'hDEADBEEF);
        len0 = 16'd0;
        req  = 2'b01;
        step();
        chk("t4a.abort", 64'({done, err, gnt}), 64'b010101);
        chk("t4a.enc", 64'({enc_reset, enc_start, pl_rd_en}), 64'd0);
        req = 2'b00;
        step();
        chk("t4a.idle", 64'({done, err, gnt, pl_rd_en}), 64'd0);
        len0 = 16'(MAX_LEN + 1);
        req  = 2'b01;
        step();
        chk("t4b.abort", 64'({done, err, gnt}), 64'b010101);
        chk("t4b.enc", 64'({enc_reset, enc_start, pl_rd_en}), 64'd0);
        req = 2'b00;
        step();
        chk("t4b.idle", 64'({done, err, enc_reset, pl_rd_en}), 64'd0);
        chk("t4.untouched", 64'(rp0), 64'(wr0 - 1));

        // 5: no enc_fin -> abort exactly TIMEOUT_CYCLES after entering WAIT_FIN
        push1(32'h11223344);
        len1 = 16'd4;
        req  = 2'b10;
        step();
        chk("t5.enc_reset", 64'(enc_reset), 64'd1);
        step();
        chk("t5.pop", 64'(pl_rd_en), 64'b10);
        step();
        chk("t5.word", 64'({enc_data_av, enc_data}), {31'd0, 1'b1, 32'h11223344});
        quiet = 1'b1;
        for (int c = 1; c < int'(TIMEOUT_CYCLES); c++) begin
            step();
            if (done !== 2'b00) quiet = 1'b0;
        end
        chk("t5.early", 64'(quiet), 64'd1);
        step();
        chk("t5.abort", 64'({done, err, enc_reset}), 64'b10101);
        req = 2'b00;
        step();
        chk("t5.idle", 64'({done, err, enc_reset, gnt}), 64'd0);

        // 6: reset on the second FEED cycle drops the transfer silently
        push1(32'hE0E0E0E0);
        push1(32'hE1E1E1E1);
        len1 = 16'd8;
        req  = 2'b10;
        step();
        chk("t6.enc_reset", 64'(enc_reset), 64'd1);
        step();
        chk("t6.pop0", 64'(pl_rd_en), 64'b10);
        step();
        chk("t6.av0", 64'({enc_data_av, enc_data}), {31'd0, 1'b1, 32'hE0E0E0E0});
        reset = 1'b1;
        #1;
        chk("t6.pop_blocked", 64'(pl_rd_en), 64'd0);
        step();
        chk("t6.outs", 64'({gnt, done, err, pl_rd_en, enc_reset, enc_start, enc_data_av, enc_udp0_tcp1}), 64'd0);
        chk("t6.data", 64'({enc_data, enc_len}), 64'd0);
        reset = 1'b0;
        push1(32'hE2E2E2E2);
        xfer("t6r", 2'b10, 2, 2'b00);
        chk("t6r.w0", 64'(rx[0]), 64'hE1E1E1E1);
        chk("t6r.w1", 64'(rx[1]), 64'hE2E2E2E2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
